// File: rtl/photonic_receiver.sv
// Destination-end photonic receiver: captures the waveguide word, keeps frames
// addressed to NODE_ID, queues them in a small FIFO and hands them to the core.
//
// FIFO occupancy state, derived from fifo_count:
//   state      | meaning
//   ST_EMPTY   | no entries, out_valid low
//   ST_PARTIAL | 1 .. FIFO_DEPTH-1 entries
//   ST_FULL    | FIFO_DEPTH entries, a match without a pop is dropped
module photonic_receiver #(
  parameter int ID_WIDTH   = 1,
  parameter int DATA_WIDTH = 1,
  parameter int NODE_ID    = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [2*ID_WIDTH+DATA_WIDTH-1:0]    rx_in,
  input  logic                                rx_strobe,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic [ID_WIDTH-1:0]                 out_src_id,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
  output logic                                overflow,
  input  logic                                overflow_clr,
  output logic [7:0]                          drop_count
);

  localparam int FW = 2*ID_WIDTH + DATA_WIDTH;
  localparam int EW = ID_WIDTH + DATA_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } fifo_state_t;

  logic              stage_vld;
  logic [FW-1:0]     stage_word;
  logic [ID_WIDTH-1:0] stage_dest;
  logic [EW-1:0]     stage_entry;
  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [EW-1:0]     head;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  fifo_state_t       fifo_state;
  logic              full;
  logic              match;
  logic              push;
  logic              pop;
  logic              drop;

  assign stage_dest  = stage_word[ID_WIDTH-1:0];
  assign stage_entry = stage_word[FW-1:ID_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_vld  <= 1'b0;
      stage_word <= '0;
    end else begin
      stage_vld  <= rx_strobe;
      stage_word <= rx_in;
    end
  end

  always_comb begin
    fifo_state = ST_PARTIAL;
    if (fifo_count == '0)
      fifo_state = ST_EMPTY;
    else if (fifo_count == CW'(FIFO_DEPTH))
      fifo_state = ST_FULL;
  end

  assign full      = (fifo_state == ST_FULL);
  assign out_valid = (fifo_state != ST_EMPTY);
  assign match     = stage_vld && (stage_dest == ID_WIDTH'(NODE_ID));
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push      = match && (!full || pop);
  assign drop      = match && full && !pop;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= stage_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // A drop coinciding with a clear restarts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (overflow_clr)
        drop_count <= 8'd1;
      else if (drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end else if (overflow_clr) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  assign head       = mem[rd_ptr];
  assign out_data   = out_valid ? head[DATA_WIDTH-1:0] : '0;
  assign out_src_id = out_valid ? head[EW-1:DATA_WIDTH] : '0;

endmodule

// File: tb/tb_photonic_receiver.sv
// Bench for photonic_receiver: expected payloads are queued by a reference
// occupancy model at each edge and compared whenever the DUT hands one over.
module tb_photonic_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] rx_in = '0;
  logic        rx_strobe = 1'b0;
  logic [7:0]  out_data;
  logic [1:0]  out_src_id;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        overflow_clr = 1'b0;
  logic [7:0]  drop_count;

  int n_chk = 0;
  int n_err = 0;

  logic [9:0]  exp_q [$];
  logic        m_vld;
  logic [11:0] m_word;
  int          m_cnt;

  photonic_receiver #(
    .ID_WIDTH(2), .DATA_WIDTH(8), .NODE_ID(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .rx_strobe(rx_strobe),
    .out_data(out_data), .out_src_id(out_src_id), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_count(fifo_count), .overflow(overflow),
    .overflow_clr(overflow_clr), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference model: 4-entry FIFO fed by a one-cycle capture stage, node id 2.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_vld = 1'b0;
      m_word = '0;
      m_cnt = 0;
    end else begin
      bit mpop, mpush;
      mpop  = (m_cnt != 0) && out_ready;
      mpush = m_vld && (m_word[1:0] == 2'd2) && (m_cnt < 4 || mpop);
      if (mpush) exp_q.push_back(m_word[11:2]);
      m_cnt  = m_cnt + int'(mpush) - int'(mpop);
      m_vld  = rx_strobe;
      m_word = rx_in;
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      chk("q_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        chk("head", {22'd0, out_src_id, out_data}, {22'd0, exp_q.pop_front()});
    end
  end

  task automatic send(input logic stb, input logic [1:0] dest, input logic [7:0] data,
                      input logic [1:0] src);
    rx_strobe = stb;
    rx_in     = {src, data, dest};
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    send(1'b0, 2'd0, 8'd0, 2'd0);
  endtask

  initial begin
    #100_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_src", 32'(out_src_id), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single frame latency
    out_ready = 1'b1;
    send(1'b1, 2'd2, 8'hA5, 2'd1);
    chk("lat_c1_valid", 32'(out_valid), 32'd0);
    idle();
    chk("lat_c2_valid", 32'(out_valid), 32'd1);
    chk("lat_c2_data", 32'(out_data), 32'hA5);
    chk("lat_c2_src", 32'(out_src_id), 32'd1);
    chk("lat_c2_count", 32'(fifo_count), 32'd1);
    idle();
    chk("lat_c3_valid", 32'(out_valid), 32'd0);
    chk("lat_c3_count", 32'(fifo_count), 32'd0);

    // filtering
    send(1'b1, 2'd3, 8'h11, 2'd0);
    send(1'b0, 2'd2, 8'h22, 2'd0);
    for (int i = 0; i < 3; i++) begin
      chk("filt_valid", 32'(out_valid), 32'd0);
      chk("filt_count", 32'(fifo_count), 32'd0);
      chk("filt_ovf", 32'(overflow), 32'd0);
      chk("filt_drop", 32'(drop_count), 32'd0);
      idle();
    end

    // overflow with six back-to-back frames
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send(1'b1, 2'd2, 8'(i), 2'd1);
    idle();
    idle();
    chk("ovf_count", 32'(fifo_count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drop", 32'(drop_count), 32'd2);
    chk("ovf_q", 32'(exp_q.size()), 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) idle();
    chk("ovf_drain_count", 32'(fifo_count), 32'd0);
    chk("ovf_drain_q", 32'(exp_q.size()), 32'd0);

    // clear with no drop
    overflow_clr = 1'b1;
    idle();
    overflow_clr = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_drop", 32'(drop_count), 32'd0);

    // full with simultaneous push and pop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b1, 2'd2, 8'h10 + 8'(i), 2'd3);
    idle();
    idle();
    chk("ff_fill", 32'(fifo_count), 32'd4);
    send(1'b1, 2'd2, 8'h20, 2'd2);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(1'b1, 2'd2, 8'h20 + 8'(i), 2'd2);
      chk("ff_count", 32'(fifo_count), 32'd4);
      chk("ff_drop", 32'(drop_count), 32'd0);
    end
    idle();
    chk("ff_tail_count", 32'(fifo_count), 32'd4);
    for (int i = 0; i < 5; i++) idle();
    chk("ff_drain", 32'(fifo_count), 32'd0);

    // saturation and clear interactions
    out_ready = 1'b0;
    for (int i = 0; i < 304; i++) send(1'b1, 2'd2, 8'(i), 2'd0);
    idle();
    idle();
    chk("sat_drop", 32'(drop_count), 32'd255);
    chk("sat_ovf", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    idle();
    overflow_clr = 1'b0;
    chk("sat_clr_ovf", 32'(overflow), 32'd0);
    chk("sat_clr_drop", 32'(drop_count), 32'd0);
    send(1'b1, 2'd2, 8'h77, 2'd0);
    overflow_clr = 1'b1;
    idle();
    overflow_clr = 1'b0;
    chk("co_ovf", 32'(overflow), 32'd1);
    chk("co_drop", 32'(drop_count), 32'd1);

    // asynchronous reset mid-burst
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) idle();
    chk("pre_rst_drain", 32'(fifo_count), 32'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b1, 2'd2, 8'h31 + 8'(i), 2'd1);
    idle();
    idle();
    chk("pre_rst_count", 32'(fifo_count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(fifo_count), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_drop", 32'(drop_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(1'b1, 2'd2, 8'h5A, 2'd3);
    chk("post_c1_valid", 32'(out_valid), 32'd0);
    idle();
    chk("post_c2_valid", 32'(out_valid), 32'd1);
    chk("post_c2_data", 32'(out_data), 32'h5A);
    chk("post_c2_src", 32'(out_src_id), 32'd3);
    idle();
    chk("post_c3_valid", 32'(out_valid), 32'd0);
    idle();
    chk("end_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
